// File: rtl/arch_map_table_pkg.sv
// Shared widths and FSM encoding for the commit-side architectural map table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arch_map_table_pkg;

  localparam int AMT_SIZE_LOGICAL      = 32;
  localparam int AMT_SIZE_LOGICAL_LOG  = 5;
  localparam int AMT_SIZE_PHYSICAL_LOG = 7;
  localparam int AMT_COMMIT_WIDTH      = 4;

  typedef enum logic {
    AMT_IDLE = 1'b0,
    AMT_COPY = 1'b1
  } amt_state_e;

endpackage

// File: rtl/arch_map_table_amt_bypass_4w.sv
// Intra-bundle dependency resolver: freed tags per slot and next-state map table.
// Latency: purely combinational.
// Backpressure: none; the caller gates vld_i when retire is not allowed.
//
// Ports:
//   amt_i      pre-bundle committed map (entry i = physical tag of logical i)
//   vld_i      per-slot retire valid (already gated by the caller)
//   log_i      per-slot logical destination
//   phy_i      per-slot newly committed physical destination
//   free_reg_o per-slot physical tag released to the free list (0 if slot invalid)
//   amt_nxt_o  map table after applying the whole bundle
module amt_bypass_4w
  import arch_map_table_pkg::*;
#(
  parameter int SIZE_LOGICAL      = AMT_SIZE_LOGICAL,
  parameter int SIZE_LOGICAL_LOG  = AMT_SIZE_LOGICAL_LOG,
  parameter int SIZE_PHYSICAL_LOG = AMT_SIZE_PHYSICAL_LOG,
  parameter int COMMIT_WIDTH      = AMT_COMMIT_WIDTH
) (
  input  logic [SIZE_LOGICAL-1:0][SIZE_PHYSICAL_LOG-1:0] amt_i,
  input  logic [COMMIT_WIDTH-1:0]                        vld_i,
  input  logic [COMMIT_WIDTH-1:0][SIZE_LOGICAL_LOG-1:0]  log_i,
  input  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] phy_i,
  output logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] free_reg_o,
  output logic [SIZE_LOGICAL-1:0][SIZE_PHYSICAL_LOG-1:0] amt_nxt_o
);

  // A slot that overwrites a register already written earlier in the same
  // bundle frees that earlier slot's new tag, not the stale committed one.
  // Scanning j upward lets the highest older writer win.
  always_comb begin
    free_reg_o = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (vld_i[k]) begin
        free_reg_o[k] = amt_i[log_i[k]];
        for (int j = 0; j < k; j++) begin
          if (vld_i[j] && (log_i[j] == log_i[k])) begin
            free_reg_o[k] = phy_i[j];
          end
        end
      end
    end
  end

  // Youngest (highest-numbered) valid writer of an entry lands last and wins.
  always_comb begin
    amt_nxt_o = amt_i;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (vld_i[k]) begin
        amt_nxt_o[log_i[k]] = phy_i[k];
      end
    end
  end

endmodule

// File: rtl/arch_map_table.sv
// Commit-side architectural map table: retires bundles, frees old tags, streams
// the committed map 4 entries/beat on recovery.
// Latency: free outputs 1 cycle after retire; copy beats start the cycle after
// recoverFlag_i. Backpressure: busy_o high during copy; retire input ignored then.
//
// Ports:
//   clk, reset                   clock / async active-low reset
//   commitValid/LogDest/PhyDest  retire bundle, slots 0..3
//   recoverFlag_i                one-cycle pulse starting (or restarting) a copy
//   freeValid/freeReg            registered releases to the speculative free list
//   busy_o, copyValid_o          copy in progress / beat valid
//   copyIdx_o, copyReg0..3_o     beat index and AMT[4*idx+j]
module arch_map_table
  import arch_map_table_pkg::*;
#(
  parameter int SIZE_LOGICAL      = AMT_SIZE_LOGICAL,
  parameter int SIZE_LOGICAL_LOG  = AMT_SIZE_LOGICAL_LOG,
  parameter int SIZE_PHYSICAL_LOG = AMT_SIZE_PHYSICAL_LOG,
  parameter int COMMIT_WIDTH      = AMT_COMMIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          commitValid0_i,
  input  logic                          commitValid1_i,
  input  logic                          commitValid2_i,
  input  logic                          commitValid3_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]   commitLogDest0_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]   commitLogDest1_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]   commitLogDest2_i,
  input  logic [SIZE_LOGICAL_LOG-1:0]   commitLogDest3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  commitPhyDest0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  commitPhyDest1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  commitPhyDest2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  commitPhyDest3_i,
  input  logic                          recoverFlag_i,
  output logic                          freeValid0_o,
  output logic                          freeValid1_o,
  output logic                          freeValid2_o,
  output logic                          freeValid3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freeReg3_o,
  output logic                          busy_o,
  output logic                          copyValid_o,
  output logic [SIZE_LOGICAL_LOG-3:0]   copyIdx_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  copyReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  copyReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  copyReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  copyReg3_o
);

  localparam int IDX_W = SIZE_LOGICAL_LOG - 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE_LOGICAL / 4 - 1);

  amt_state_e state_q, state_d;

  logic [SIZE_LOGICAL-1:0][SIZE_PHYSICAL_LOG-1:0] amt_q, amt_d, amt_nxt;
  logic [IDX_W-1:0]                               copy_idx_q, copy_idx_d;
  logic [COMMIT_WIDTH-1:0]                        free_vld_q, free_vld_d;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] free_reg_q, free_reg_d;

  logic [COMMIT_WIDTH-1:0]                        commit_vld;
  logic [COMMIT_WIDTH-1:0][SIZE_LOGICAL_LOG-1:0]  commit_log;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] commit_phy;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] freed;
  logic                                           retire_en;
  logic                                           copy_last;

  assign commit_vld = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
  assign commit_log = {commitLogDest3_i, commitLogDest2_i, commitLogDest1_i, commitLogDest0_i};
  assign commit_phy = {commitPhyDest3_i, commitPhyDest2_i, commitPhyDest1_i, commitPhyDest0_i};

  // Retire only from IDLE; this includes the cycle recoverFlag_i arrives, so
  // those older commits are in the table before the first copy beat reads it.
  assign retire_en = (state_q == AMT_IDLE);
  assign copy_last = (copy_idx_q == IDX_LAST);

  amt_bypass_4w #(
    .SIZE_LOGICAL      (SIZE_LOGICAL),
    .SIZE_LOGICAL_LOG  (SIZE_LOGICAL_LOG),
    .SIZE_PHYSICAL_LOG (SIZE_PHYSICAL_LOG),
    .COMMIT_WIDTH      (COMMIT_WIDTH)
  ) u_bypass (
    .amt_i      (amt_q),
    .vld_i      (free_vld_d),
    .log_i      (commit_log),
    .phy_i      (commit_phy),
    .free_reg_o (freed),
    .amt_nxt_o  (amt_nxt)
  );

  always_comb begin
    free_vld_d = retire_en ? commit_vld : '0;
    free_reg_d = freed;
    amt_d      = amt_nxt;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= AMT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AMT_IDLE: if (recoverFlag_i) state_d = AMT_COPY;
      AMT_COPY: if (!recoverFlag_i && copy_last) state_d = AMT_IDLE;
      default:  state_d = AMT_IDLE;
    endcase
  end

  // Beat counter: a new recovery (from IDLE or mid-copy) restarts at 0;
  // the terminal compare returns it to 0 so it never wraps by overflow.
  always_comb begin
    copy_idx_d = copy_idx_q;
    if (recoverFlag_i) begin
      copy_idx_d = '0;
    end else if (state_q == AMT_COPY) begin
      copy_idx_d = copy_last ? '0 : copy_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      copy_idx_q <= '0;
      free_vld_q <= '0;
      free_reg_q <= '0;
      for (int i = 0; i < SIZE_LOGICAL; i++) begin
        amt_q[i] <= SIZE_PHYSICAL_LOG'(i);
      end
    end else begin
      copy_idx_q <= copy_idx_d;
      free_vld_q <= free_vld_d;
      free_reg_q <= free_reg_d;
      amt_q      <= amt_d;
    end
  end

  // FSM: outputs. Copy data is zeroed outside COPY so the port is quiet in IDLE.
  always_comb begin
    busy_o      = (state_q == AMT_COPY);
    copyValid_o = (state_q == AMT_COPY);
    copyIdx_o   = copy_idx_q;
    copyReg0_o  = '0;
    copyReg1_o  = '0;
    copyReg2_o  = '0;
    copyReg3_o  = '0;
    if (state_q == AMT_COPY) begin
      copyReg0_o = amt_q[{copy_idx_q, 2'd0}];
      copyReg1_o = amt_q[{copy_idx_q, 2'd1}];
      copyReg2_o = amt_q[{copy_idx_q, 2'd2}];
      copyReg3_o = amt_q[{copy_idx_q, 2'd3}];
    end
  end

  assign freeValid0_o = free_vld_q[0];
  assign freeValid1_o = free_vld_q[1];
  assign freeValid2_o = free_vld_q[2];
  assign freeValid3_o = free_vld_q[3];
  assign freeReg0_o   = free_reg_q[0];
  assign freeReg1_o   = free_reg_q[1];
  assign freeReg2_o   = free_reg_q[2];
  assign freeReg3_o   = free_reg_q[3];

endmodule

// File: tb/tb_arch_map_table.sv
// Directed self-checking bench for arch_map_table.
// Drives inputs 1 ns after the rising edge and samples registered outputs there.
// Expected values are hand-computed constants.
module tb_arch_map_table;

  logic       clk;
  logic       reset;
  logic [3:0] cv;
  logic [4:0] cl [4];
  logic [6:0] cp [4];
  logic       rec;

  logic       fv0, fv1, fv2, fv3;
  logic [6:0] fr0, fr1, fr2, fr3;
  logic       busy, cvld;
  logic [2:0] cidx;
  logic [6:0] cr0, cr1, cr2, cr3;
  logic [3:0] fv;

  int checks = 0;
  int errors = 0;

  assign fv = {fv3, fv2, fv1, fv0};

  arch_map_table dut (
    .clk              (clk),
    .reset            (reset),
    .commitValid0_i   (cv[0]),
    .commitValid1_i   (cv[1]),
    .commitValid2_i   (cv[2]),
    .commitValid3_i   (cv[3]),
    .commitLogDest0_i (cl[0]),
    .commitLogDest1_i (cl[1]),
    .commitLogDest2_i (cl[2]),
    .commitLogDest3_i (cl[3]),
    .commitPhyDest0_i (cp[0]),
    .commitPhyDest1_i (cp[1]),
    .commitPhyDest2_i (cp[2]),
    .commitPhyDest3_i (cp[3]),
    .recoverFlag_i    (rec),
    .freeValid0_o     (fv0),
    .freeValid1_o     (fv1),
    .freeValid2_o     (fv2),
    .freeValid3_o     (fv3),
    .freeReg0_o       (fr0),
    .freeReg1_o       (fr1),
    .freeReg2_o       (fr2),
    .freeReg3_o       (fr3),
    .busy_o           (busy),
    .copyValid_o      (cvld),
    .copyIdx_o        (cidx),
    .copyReg0_o       (cr0),
    .copyReg1_o       (cr1),
    .copyReg2_o       (cr2),
    .copyReg3_o       (cr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_in();
    cv  = '0;
    rec = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cl[i] = '0;
      cp[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    step();
    step();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_cvld", cvld, 0);
    chk("rst_cidx", cidx, 0);
    chk("rst_fv", fv, 0);
    chk("rst_cr0", cr0, 0);
    chk("rst_fr0", fr0, 0);

    reset = 1'b1;
    step();

    // Single commit: log 3 -> phy 40 frees the reset mapping 3
    cv[0] = 1'b1; cl[0] = 5'd3; cp[0] = 7'd40;
    step();
    clear_in();
    chk("c1_fv", fv, 4'b0001);
    chk("c1_fr0", fr0, 3);
    chk("c1_fr1", fr1, 0);
    chk("c1_fr3", fr3, 0);

    // Four writers of log 5: each frees its predecessor's new tag
    cv = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cl[i] = 5'd5;
      cp[i] = 7'(50 + i);
    end
    step();
    clear_in();
    chk("c2_fv", fv, 4'b1111);
    chk("c2_fr0", fr0, 5);
    chk("c2_fr1", fr1, 50);
    chk("c2_fr2", fr2, 51);
    chk("c2_fr3", fr3, 52);

    // Sparse bundle: slots 1 and 3 only
    cv = 4'b1010;
    cl[1] = 5'd7; cp[1] = 7'd60;
    cl[3] = 5'd8; cp[3] = 7'd61;
    step();
    clear_in();
    chk("c3_fv", fv, 4'b1010);
    chk("c3_fr0", fr0, 0);
    chk("c3_fr1", fr1, 7);
    chk("c3_fr2", fr2, 0);
    chk("c3_fr3", fr3, 8);

    step();
    chk("idle_fv", fv, 0);

    // Recovery copy
    rec = 1'b1;
    step();
    rec = 1'b0;
    chk("cp_b0_busy", busy, 1);
    chk("cp_b0_cvld", cvld, 1);
    chk("cp_b0_idx", cidx, 0);
    chk("cp_b0_r0", cr0, 0);
    chk("cp_b0_r1", cr1, 1);
    chk("cp_b0_r2", cr2, 2);
    chk("cp_b0_r3", cr3, 40);
    step();
    chk("cp_b1_idx", cidx, 1);
    chk("cp_b1_r0", cr0, 4);
    chk("cp_b1_r1", cr1, 53);
    chk("cp_b1_r2", cr2, 6);
    chk("cp_b1_r3", cr3, 60);
    step();
    chk("cp_b2_idx", cidx, 2);
    chk("cp_b2_r0", cr0, 61);
    chk("cp_b2_r1", cr1, 9);
    // Commit during COPY must be ignored
    cv[0] = 1'b1; cl[0] = 5'd9; cp[0] = 7'd99;
    step();
    clear_in();
    chk("cp_b3_idx", cidx, 3);
    chk("cp_b3_fv", fv, 0);
    step();
    step();
    step();
    step();
    chk("cp_b7_idx", cidx, 7);
    chk("cp_b7_busy", busy, 1);
    step();
    chk("cp_end_busy", busy, 0);
    chk("cp_end_cvld", cvld, 0);
    chk("cp_end_idx", cidx, 0);
    chk("cp_end_r0", cr0, 0);

    // Recovery together with an older commit: commit lands first
    rec = 1'b1;
    cv[0] = 1'b1; cl[0] = 5'd0; cp[0] = 7'd70;
    step();
    clear_in();
    chk("rc_fv", fv, 4'b0001);
    chk("rc_fr0", fr0, 0);
    chk("rc_busy", busy, 1);
    chk("rc_idx", cidx, 0);
    chk("rc_r0", cr0, 70);
    chk("rc_r3", cr3, 40);
    step();
    step();
    chk("rc_b2_r1_ignored", cr1, 9);
    step();
    step();
    chk("rc_b4_idx", cidx, 4);

    // Restart mid-copy
    rec = 1'b1;
    step();
    rec = 1'b0;
    chk("rs_idx0", cidx, 0);
    chk("rs_busy0", busy, 1);
    for (int b = 1; b < 8; b++) begin
      step();
      chk($sformatf("rs_idx%0d", b), cidx, b);
      chk($sformatf("rs_busy%0d", b), busy, 1);
    end
    step();
    chk("rs_end_busy", busy, 0);

    // Reset mid-copy
    rec = 1'b1;
    step();
    rec = 1'b0;
    step();
    step();
    chk("rm_idx2", cidx, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_cvld", cvld, 0);
    chk("rm_idx", cidx, 0);
    chk("rm_fv", fv, 0);
    step();
    reset = 1'b1;
    rec = 1'b1;
    step();
    rec = 1'b0;
    chk("rf_idx0", cidx, 0);
    chk("rf_r0", cr0, 0);
    chk("rf_r3", cr3, 3);
    step();
    chk("rf_r1_amt5", cr1, 5);
    chk("rf_r3_amt7", cr3, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
